// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the F-stage PC and delay-slot flag, picks the
// next fetch address by priority (reset > req > stall > eret > npc) and flags AdEL.
module fetch_pc_ctrl #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic [31:0] npc,
    input  logic        delayslot,
    output logic [31:0] f_pc,
    output logic        f_bd,
    output logic [4:0]  f_exccode,
    output logic        fd_flush,
    output logic [1:0]  f_state
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_EXC  = 2'd2,
        ST_ERET = 2'd3
    } state_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_NONE = 5'd0;

    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    state_e      state_q, state_d;

    // The state only records why the PC last changed, so it never feeds back
    // into the decision below.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        pc_d    = pc_q;
        bd_d    = bd_q;
        state_d = ST_RUN;
        if (req) begin
            pc_d    = EXC_VECTOR;
            bd_d    = 1'b0;
            state_d = ST_EXC;
        end else if (stall) begin
            state_d = ST_HOLD;
        end else if (eret) begin
            pc_d    = epc;
            bd_d    = 1'b0;
            state_d = ST_ERET;
        end else begin
            pc_d    = npc;
            bd_d    = delayslot;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            pc_q    <= PC_RESET;
            bd_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            state_q <= state_d;
        end
    end

    // ERET has no delay slot, so whatever was fetched behind it is squashed;
    // a stalled ERET stays in D and flushes only once it is honoured.
    assign fd_flush = req | (eret & ~stall);

    // Illegal addresses are still fetched; CP0 picks up the AdEL code later.
    logic pc_illegal;
    assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

    assign f_exccode = pc_illegal ? EXC_ADEL : EXC_NONE;
    assign f_pc      = pc_q;
    assign f_bd      = bd_q;
    assign f_state   = state_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: one task per scenario, hand-computed
// expectations, inputs driven and outputs sampled 1 ns after the rising edge.
module tb_fetch_pc_ctrl;

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] EXC  = 2'd2;
    localparam logic [1:0] ERET = 2'd3;

    logic        clk = 1'b0;
    logic        reset, stall, req, eret, delayslot;
    logic [31:0] epc, npc;
    logic [31:0] f_pc;
    logic        f_bd;
    logic [4:0]  f_exccode;
    logic        fd_flush;
    logic [1:0]  f_state;

    int vectors = 0;
    int miscompares = 0;

    fetch_pc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req       (req),
        .eret      (eret),
        .epc       (epc),
        .npc       (npc),
        .delayslot (delayslot),
        .f_pc      (f_pc),
        .f_bd      (f_bd),
        .f_exccode (f_exccode),
        .fd_flush  (fd_flush),
        .f_state   (f_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; req = 1'b0; eret = 1'b0;
        delayslot = 1'b0; epc = 32'h0; npc = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        npc   = 32'h0000_5555;
        step();
        step();
        reset = 1'b0;
        npc   = 32'h0000_3000;
        #1;
        vectors++;
        if (f_pc !== 32'h0000_3000) begin miscompares++; $display("FAIL reset_pc: got %h want %h", f_pc, 32'h0000_3000); end
        vectors++;
        if (f_bd !== 1'b0) begin miscompares++; $display("FAIL reset_bd: got %b want 0", f_bd); end
        vectors++;
        if (f_state !== RUN) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", f_state, RUN); end
        vectors++;
        if (f_exccode !== 5'd0) begin miscompares++; $display("FAIL reset_exccode: got %0d want 0", f_exccode); end
        vectors++;
        if (fd_flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b want 0", fd_flush); end
    endtask

    task automatic test_free_run();
        logic [31:0] seq [3];
        seq[0] = 32'h0000_3000; seq[1] = 32'h0000_3004; seq[2] = 32'h0000_3008;
        foreach (seq[i]) begin
            npc = seq[i];
            step();
            vectors++;
            if (f_pc !== seq[i]) begin miscompares++; $display("FAIL run_pc[%0d]: got %h want %h", i, f_pc, seq[i]); end
            vectors++;
            if (f_bd !== 1'b0 || f_state !== RUN || f_exccode !== 5'd0) begin
                miscompares++;
                $display("FAIL run_flags[%0d]: got bd=%b st=%0d exc=%0d want bd=0 st=0 exc=0", i, f_bd, f_state, f_exccode);
            end
        end
    endtask

    task automatic test_branch();
        npc = 32'h0000_300c; step();
        npc = 32'h0000_3010; step();
        // Branch at 3010: its delay slot 3014 is fetched with BD set.
        delayslot = 1'b1; npc = 32'h0000_3014; step();
        vectors++;
        if (f_pc !== 32'h0000_3014 || f_bd !== 1'b1) begin
            miscompares++; $display("FAIL branch_slot: got pc=%h bd=%b want pc=00003014 bd=1", f_pc, f_bd);
        end
        delayslot = 1'b0; npc = 32'h0000_3100; step();
        vectors++;
        if (f_pc !== 32'h0000_3100 || f_bd !== 1'b0) begin
            miscompares++; $display("FAIL branch_target: got pc=%h bd=%b want pc=00003100 bd=0", f_pc, f_bd);
        end
    endtask

    task automatic test_stall();
        npc = 32'h0000_3020; step();
        stall = 1'b1; npc = 32'h0000_3abc; delayslot = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (f_pc !== 32'h0000_3020 || f_state !== HOLD || f_bd !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got pc=%h st=%0d bd=%b want pc=00003020 st=1 bd=0", k, f_pc, f_state, f_bd);
            end
        end
        stall = 1'b0; delayslot = 1'b0; npc = 32'h0000_3024; step();
        vectors++;
        if (f_pc !== 32'h0000_3024 || f_state !== RUN) begin
            miscompares++; $display("FAIL stall_release: got pc=%h st=%0d want pc=00003024 st=0", f_pc, f_state);
        end
        // A set BD flag must survive a stall too.
        delayslot = 1'b1; npc = 32'h0000_3028; step();
        stall = 1'b1; delayslot = 1'b0; npc = 32'h0000_302c; step();
        vectors++;
        if (f_pc !== 32'h0000_3028 || f_bd !== 1'b1) begin
            miscompares++; $display("FAIL stall_bd_hold: got pc=%h bd=%b want pc=00003028 bd=1", f_pc, f_bd);
        end
        stall = 1'b0;
    endtask

    task automatic test_req();
        npc = 32'h0000_3040; step();
        stall = 1'b1; req = 1'b1; npc = 32'h0000_3044;
        #1;
        vectors++;
        if (fd_flush !== 1'b1) begin miscompares++; $display("FAIL req_stall_flush: got %b want 1", fd_flush); end
        step();
        vectors++;
        if (f_pc !== 32'h0000_4180 || f_bd !== 1'b0 || f_state !== EXC) begin
            miscompares++; $display("FAIL req_stall_redirect: got pc=%h bd=%b st=%0d want pc=00004180 bd=0 st=2", f_pc, f_bd, f_state);
        end
        // req coincident with eret: the exception vector wins.
        stall = 1'b0; npc = 32'h0000_4184; step();
        req = 1'b1; eret = 1'b1; epc = 32'h0000_3058; delayslot = 1'b1;
        #1;
        vectors++;
        if (fd_flush !== 1'b1) begin miscompares++; $display("FAIL req_eret_flush: got %b want 1", fd_flush); end
        step();
        vectors++;
        if (f_pc !== 32'h0000_4180 || f_state !== EXC || f_bd !== 1'b0) begin
            miscompares++; $display("FAIL req_eret_redirect: got pc=%h st=%0d bd=%b want pc=00004180 st=2 bd=0", f_pc, f_state, f_bd);
        end
        req = 1'b0; eret = 1'b0; delayslot = 1'b0;
    endtask

    task automatic test_eret();
        eret = 1'b1; epc = 32'h0000_3058; npc = 32'h0000_3200; delayslot = 1'b1;
        #1;
        vectors++;
        if (fd_flush !== 1'b1) begin miscompares++; $display("FAIL eret_flush: got %b want 1", fd_flush); end
        step();
        vectors++;
        if (f_pc !== 32'h0000_3058 || f_state !== ERET || f_bd !== 1'b0) begin
            miscompares++; $display("FAIL eret_redirect: got pc=%h st=%0d bd=%b want pc=00003058 st=3 bd=0", f_pc, f_state, f_bd);
        end
        // Stalled ERET: no flush, no redirect until the stall drops.
        eret = 1'b0; delayslot = 1'b0; npc = 32'h0000_305c; step();
        eret = 1'b1; stall = 1'b1; epc = 32'h0000_3060; npc = 32'h0000_3300;
        #1;
        vectors++;
        if (fd_flush !== 1'b0) begin miscompares++; $display("FAIL eret_stall_flush: got %b want 0", fd_flush); end
        step();
        vectors++;
        if (f_pc !== 32'h0000_305c || f_state !== HOLD) begin
            miscompares++; $display("FAIL eret_stall_hold: got pc=%h st=%0d want pc=0000305c st=1", f_pc, f_state);
        end
        stall = 1'b0;
        #1;
        vectors++;
        if (fd_flush !== 1'b1) begin miscompares++; $display("FAIL eret_unstall_flush: got %b want 1", fd_flush); end
        step();
        vectors++;
        if (f_pc !== 32'h0000_3060 || f_state !== ERET) begin
            miscompares++; $display("FAIL eret_unstall_redirect: got pc=%h st=%0d want pc=00003060 st=3", f_pc, f_state);
        end
        eret = 1'b0;
    endtask

    task automatic test_adel();
        logic [31:0] addr [7];
        logic [4:0]  code [7];
        addr[0] = 32'h0000_3002; code[0] = 5'd4;
        addr[1] = 32'h0000_2ffc; code[1] = 5'd4;
        addr[2] = 32'h0000_7000; code[2] = 5'd4;
        addr[3] = 32'h0000_6ffc; code[3] = 5'd0;
        addr[4] = 32'h0000_3000; code[4] = 5'd0;
        addr[5] = 32'h0000_6ffd; code[5] = 5'd4;
        addr[6] = 32'hffff_fffc; code[6] = 5'd4;
        foreach (addr[i]) begin
            npc = addr[i];
            step();
            vectors++;
            if (f_pc !== addr[i] || f_exccode !== code[i]) begin
                miscompares++;
                $display("FAIL adel[%0d]: got pc=%h exc=%0d want pc=%h exc=%0d", i, f_pc, f_exccode, addr[i], code[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        npc = 32'h0000_3500; step();
        reset = 1'b1; req = 1'b1; step();
        vectors++;
        if (f_pc !== 32'h0000_3000 || f_state !== RUN || f_bd !== 1'b0) begin
            miscompares++; $display("FAIL reset_over_req: got pc=%h st=%0d bd=%b want pc=00003000 st=0 bd=0", f_pc, f_state, f_bd);
        end
        reset = 1'b0; req = 1'b0; npc = 32'h0000_3600; delayslot = 1'b1; step();
        stall = 1'b1; step();
        reset = 1'b1; step();
        vectors++;
        if (f_pc !== 32'h0000_3000 || f_state !== RUN || f_bd !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_stall: got pc=%h st=%0d bd=%b want pc=00003000 st=0 bd=0", f_pc, f_state, f_bd);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        // Alternating redirects on consecutive edges, each visible one cycle later.
        npc = 32'h0000_3700; step();
        req = 1'b1; step();
        req = 1'b0; eret = 1'b1; epc = 32'h0000_3704; step();
        vectors++;
        if (f_pc !== 32'h0000_3704 || f_state !== ERET) begin
            miscompares++; $display("FAIL b2b_eret: got pc=%h st=%0d want pc=00003704 st=3", f_pc, f_state);
        end
        eret = 1'b0; npc = 32'h0000_3708; step();
        vectors++;
        if (f_pc !== 32'h0000_3708 || f_state !== RUN) begin
            miscompares++; $display("FAIL b2b_run: got pc=%h st=%0d want pc=00003708 st=0", f_pc, f_state);
        end
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_free_run();
        test_branch();
        test_stall();
        test_req();
        test_eret();
        test_adel();
        test_reset_priority();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
